// File: rtl/commit_queue_if.sv
// Commit queue bus: enqueue side from rename/execute, regfile write side out.
// master drives enqueue/control, slave is the commit queue itself.
interface commit_queue_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int OW = $clog2(DEPTH) + 1;

  logic [1:0]          enq_valid;
  logic [1:0]          enq_wen;
  logic [1:0][AW-1:0]  enq_addr;
  logic [1:0][DW-1:0]  enq_data;
  logic                enq_ready;
  logic                flush;
  logic                cmt_stall;
  logic [1:0]          rf_wena;
  logic [1:0][AW-1:0]  rf_waddr;
  logic [1:0][DW-1:0]  rf_wdata;
  logic [1:0]          cmt_count;
  logic [OW-1:0]       occupancy;

  modport master (
    output enq_valid, enq_wen, enq_addr, enq_data, flush, cmt_stall,
    input  enq_ready, rf_wena, rf_waddr, rf_wdata, cmt_count, occupancy
  );

  modport slave (
    input  enq_valid, enq_wen, enq_addr, enq_data, flush, cmt_stall,
    output enq_ready, rf_wena, rf_waddr, rf_wdata, cmt_count, occupancy
  );
endinterface

// File: rtl/commit_queue.sv
// Dual-issue in-order commit queue: circular buffer of {wen, addr, data},
// retiring up to two entries per cycle into a two-port register file.
module commit_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  commit_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] READY_MAX = OW'(DEPTH - 2);
  localparam logic [OW-1:0] OCC_TWO   = OW'(2);

  function automatic logic [1:0] pop2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

  logic [PW-1:0]  head_r, tail_r;
  logic [OW-1:0]  occ_r;
  logic           mem_wen_r  [DEPTH];
  logic [AW-1:0]  mem_addr_r [DEPTH];
  logic [DW-1:0]  mem_data_r [DEPTH];

  logic [1:0]          rf_wena_r;
  logic [1:0][AW-1:0]  rf_waddr_r;
  logic [1:0][DW-1:0]  rf_wdata_r;
  logic [1:0]          cmt_count_r;

  logic                enq_ready_s, enq_fire_s;
  logic [1:0]          enq_cnt_s, deq_cnt_s;
  logic [PW-1:0]       head1_s, wr_idx1_s;
  logic [1:0]          st_wen_s;
  logic [1:0]          nxt_wena_s;
  logic [1:0][AW-1:0]  nxt_waddr_s;
  logic [1:0][DW-1:0]  nxt_wdata_s;

  assign head1_s   = head_r + {{(PW-1){1'b0}}, 1'b1};
  assign wr_idx1_s = tail_r + {{(PW-1){1'b0}}, bus.enq_valid[0]};
  assign st_wen_s[0] = bus.enq_wen[0] & (bus.enq_addr[0] != {AW{1'b0}});
  assign st_wen_s[1] = bus.enq_wen[1] & (bus.enq_addr[1] != {AW{1'b0}});

  // Enqueue/dequeue counts; entries written this edge are never popped this edge.
  always_comb begin
    enq_ready_s = (occ_r <= READY_MAX);
    enq_fire_s  = enq_ready_s & ~bus.flush;
    if (enq_fire_s) begin
      enq_cnt_s = pop2(bus.enq_valid);
    end else begin
      enq_cnt_s = 2'd0;
    end
    if (bus.flush || bus.cmt_stall) begin
      deq_cnt_s = 2'd0;
    end else if (occ_r >= OCC_TWO) begin
      deq_cnt_s = 2'd2;
    end else begin
      deq_cnt_s = occ_r[1:0];
    end
  end

  // Regfile write port selection, merging same-register double writes onto port 0.
  always_comb begin
    nxt_wena_s  = 2'b00;
    nxt_waddr_s = '{default: {AW{1'b0}}};
    nxt_wdata_s = '{default: {DW{1'b0}}};
    case (deq_cnt_s)
      2'd2: begin
        if (mem_wen_r[head_r] && mem_wen_r[head1_s] &&
            (mem_addr_r[head_r] == mem_addr_r[head1_s])) begin
          nxt_wena_s     = 2'b01;
          nxt_waddr_s[0] = mem_addr_r[head1_s];
          nxt_wdata_s[0] = mem_data_r[head1_s];
        end else begin
          nxt_wena_s     = {mem_wen_r[head1_s], mem_wen_r[head_r]};
          nxt_waddr_s[0] = mem_addr_r[head_r];
          nxt_wdata_s[0] = mem_data_r[head_r];
          nxt_waddr_s[1] = mem_addr_r[head1_s];
          nxt_wdata_s[1] = mem_data_r[head1_s];
        end
      end
      2'd1: begin
        nxt_wena_s     = {1'b0, mem_wen_r[head_r]};
        nxt_waddr_s[0] = mem_addr_r[head_r];
        nxt_wdata_s[0] = mem_data_r[head_r];
      end
      default: begin
        nxt_wena_s = 2'b00;
      end
    endcase
  end

  // Entry storage; contents are only observed after being written.
  always_ff @(posedge clk) begin
    if (enq_fire_s && bus.enq_valid[0]) begin
      mem_wen_r[tail_r]  <= st_wen_s[0];
      mem_addr_r[tail_r] <= bus.enq_addr[0];
      mem_data_r[tail_r] <= bus.enq_data[0];
    end
    if (enq_fire_s && bus.enq_valid[1]) begin
      mem_wen_r[wr_idx1_s]  <= st_wen_s[1];
      mem_addr_r[wr_idx1_s] <= bus.enq_addr[1];
      mem_data_r[wr_idx1_s] <= bus.enq_data[1];
    end
  end

  // Pointers and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= {PW{1'b0}};
      tail_r <= {PW{1'b0}};
      occ_r  <= {OW{1'b0}};
    end else if (bus.flush) begin
      head_r <= {PW{1'b0}};
      tail_r <= {PW{1'b0}};
      occ_r  <= {OW{1'b0}};
    end else begin
      head_r <= head_r + PW'(deq_cnt_s);
      tail_r <= tail_r + PW'(enq_cnt_s);
      occ_r  <= occ_r + OW'(enq_cnt_s) - OW'(deq_cnt_s);
    end
  end

  // Registered regfile write ports and retire count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wena_r   <= 2'b00;
      rf_waddr_r  <= '{default: {AW{1'b0}}};
      rf_wdata_r  <= '{default: {DW{1'b0}}};
      cmt_count_r <= 2'd0;
    end else begin
      rf_wena_r   <= nxt_wena_s;
      rf_waddr_r  <= nxt_waddr_s;
      rf_wdata_r  <= nxt_wdata_s;
      cmt_count_r <= deq_cnt_s;
    end
  end

  assign bus.enq_ready = enq_ready_s;
  assign bus.rf_wena   = rf_wena_r;
  assign bus.rf_waddr  = rf_waddr_r;
  assign bus.rf_wdata  = rf_wdata_r;
  assign bus.cmt_count = cmt_count_r;
  assign bus.occupancy = occ_r;
endmodule
